// File: rtl/mem_access.sv
// MEM pipeline stage: passes ALU results through to write-back and runs
// loads/stores on a req/ack data bus (big-endian lanes, sign/zero extension).
module mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_dest_addr,
  input  logic        mem_wreg,
  input  logic [31:0] mem_dest_data,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  output logic [4:0]  wb_dest_addr,
  output logic        wb_wreg,
  output logic [31:0] wb_dest_data,
  output logic        stall_req,
  output logic        addr_err,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic [3:0] lane_be(input logic [3:0] op, input logic [1:0] off);
    case (op)
      OP_LB, OP_LBU, OP_SB: lane_be = 4'b1000 >> off;
      OP_LH, OP_LHU, OP_SH: lane_be = off[1] ? 4'b0011 : 4'b1100;
      OP_LW, OP_SW:         lane_be = 4'b1111;
      default:              lane_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] d);
    case (op)
      OP_SB:   store_data = {4{d[7:0]}};
      OP_SH:   store_data = {2{d[15:0]}};
      OP_SW:   store_data = d;
      default: store_data = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] off,
                                               input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      2'd3:    b = d[7:0];
      default: b = 8'd0;
    endcase
    h = off[1] ? d[15:0] : d[31:16];
    case (op)
      OP_LB:   load_extract = {{24{b[7]}}, b};
      OP_LBU:  load_extract = {24'd0, b};
      OP_LH:   load_extract = {{16{h[15]}}, h};
      OP_LHU:  load_extract = {16'd0, h};
      OP_LW:   load_extract = d;
      default: load_extract = 32'd0;
    endcase
  endfunction

  state_t      r_state, w_next;
  logic [3:0]  r_op;
  logic [1:0]  r_off;
  logic [4:0]  r_dest;
  logic        r_wreg;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_dmem_req, r_dmem_we;
  logic [31:0] r_dmem_addr, r_dmem_wdata;
  logic [3:0]  r_dmem_be;

  logic        w_valid, w_misalign, w_timeout;
  logic [4:0]  w_wb_dest_addr;
  logic        w_wb_wreg, w_stall, w_addr_err, w_bus_err;
  logic [31:0] w_wb_dest_data;

  assign w_valid    = is_load(mem_op) || is_store(mem_op);
  assign w_misalign = (((mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH)) && mem_addr[0])
                    || (((mem_op == OP_LW) || (mem_op == OP_SW)) && (mem_addr[1:0] != 2'd0));
  assign w_timeout  = (r_cnt + 8'd1) == TIMEOUT_L;

  // Next-state and combinational stage outputs
  always_comb begin
    w_next         = r_state;
    w_wb_dest_addr = mem_dest_addr;
    w_wb_wreg      = mem_wreg;
    w_wb_dest_data = mem_dest_data;
    w_stall        = 1'b0;
    w_addr_err     = 1'b0;
    w_bus_err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_valid && w_misalign) begin
          w_addr_err = 1'b1;
          w_wb_wreg  = 1'b0;
        end else if (w_valid) begin
          // a stalled access must not also commit the pass-through value
          w_stall   = 1'b1;
          w_wb_wreg = 1'b0;
          w_next    = S_REQ;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_REQ: begin
        w_stall   = 1'b1;
        w_wb_wreg = 1'b0;
        if (dmem_ack || w_timeout) begin
          w_next = S_DONE;
        end else begin
          w_next = S_REQ;
        end
      end
      S_DONE: begin
        w_wb_dest_addr = r_dest;
        w_wb_wreg      = r_wreg && is_load(r_op) && !r_err;
        w_wb_dest_data = load_extract(r_op, r_off, r_rdata);
        w_bus_err      = r_err;
        w_next         = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State, captured request and bus registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= 4'd0;
      r_off        <= 2'd0;
      r_dest       <= 5'd0;
      r_wreg       <= 1'b0;
      r_cnt        <= 8'd0;
      r_rdata      <= 32'd0;
      r_err        <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= 32'd0;
      r_dmem_be    <= 4'd0;
      r_dmem_wdata <= 32'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_next == S_REQ) begin
            r_op         <= mem_op;
            r_off        <= mem_addr[1:0];
            r_dest       <= mem_dest_addr;
            r_wreg       <= mem_wreg;
            r_cnt        <= 8'd0;
            r_rdata      <= 32'd0;
            r_err        <= 1'b0;
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= is_store(mem_op);
            r_dmem_addr  <= {mem_addr[31:2], 2'b00};
            r_dmem_be    <= lane_be(mem_op, mem_addr[1:0]);
            r_dmem_wdata <= store_data(mem_op, mem_dest_data);
          end else begin
            r_err <= 1'b0;
          end
        end
        S_REQ: begin
          // ack wins over a timeout landing on the same cycle
          if (dmem_ack) begin
            r_rdata    <= dmem_rdata;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
          end else if (w_timeout) begin
            r_err      <= 1'b1;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_err <= 1'b0;
        end
        default: begin
          r_dmem_req <= 1'b0;
          r_dmem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign wb_dest_addr = rst ? 5'd0  : w_wb_dest_addr;
  assign wb_wreg      = rst ? 1'b0  : w_wb_wreg;
  assign wb_dest_data = rst ? 32'd0 : w_wb_dest_data;
  assign stall_req    = rst ? 1'b0  : w_stall;
  assign addr_err     = rst ? 1'b0  : w_addr_err;
  assign bus_err      = rst ? 1'b0  : w_bus_err;
  assign dmem_req     = r_dmem_req;
  assign dmem_we      = r_dmem_we;
  assign dmem_addr    = r_dmem_addr;
  assign dmem_be      = r_dmem_be;
  assign dmem_wdata   = r_dmem_wdata;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboarded bench for mem_access: expected write-back results are queued
// when an op is issued and compared when the stage produces its result.
module tb_mem_access;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_dest_addr;
  logic        mem_wreg;
  logic [31:0] mem_dest_data;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [4:0]  wb_dest_addr;
  logic        wb_wreg;
  logic [31:0] wb_dest_data;
  logic        stall_req, addr_err, bus_err;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  dest;
    logic        wreg;
    logic [31:0] data;
    logic        chk_data;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_dest_addr(mem_dest_addr), .mem_wreg(mem_wreg), .mem_dest_data(mem_dest_data),
    .mem_op(mem_op), .mem_addr(mem_addr),
    .wb_dest_addr(wb_dest_addr), .wb_wreg(wb_wreg), .wb_dest_data(wb_dest_data),
    .stall_req(stall_req), .addr_err(addr_err), .bus_err(bus_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ack_at: REQ cycle (1-based) in which the bus acks; 0 = never
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] d, input logic [4:0] dest, input logic wreg,
                       input logic [31:0] rdata, input int ack_at);
    logic        ld, st, half, word, mis, err;
    logic [1:0]  k;
    logic [7:0]  b;
    logic [15:0] h;
    logic [3:0]  be;
    logic [31:0] wd, ld_val;
    int          exp_reqs, reqs, stalls;
    bit          done;
    exp_t        e, g;
    ld   = (op >= 4'd1) && (op <= 4'd5);
    st   = (op >= 4'd6) && (op <= 4'd8);
    half = (op == 4'd3) || (op == 4'd4) || (op == 4'd7);
    word = (op == 4'd5) || (op == 4'd8);
    k    = addr[1:0];
    mis  = (half && addr[0]) || (word && (k != 2'd0));
    @(negedge clk);
    mem_op = op; mem_addr = addr; mem_dest_data = d; mem_dest_addr = dest; mem_wreg = wreg;
    #1;
    if (!(ld || st)) begin
      e = '{dest: dest, wreg: wreg, data: d, chk_data: 1'b1, err: 1'b0};
      sb_q.push_back(e);
      g = sb_q.pop_front();
      check({tag, " pass wb"}, {wb_dest_addr, wb_wreg, wb_dest_data}, {g.dest, g.wreg, g.data});
      check({tag, " pass stall/err"}, {stall_req, addr_err}, 2'b00);
    end else if (mis) begin
      check({tag, " misalign flags"}, {addr_err, stall_req, wb_wreg}, 3'b100);
      @(negedge clk);
      mem_op = 4'd0;
      #1;
      check({tag, " misalign after"}, {addr_err, dmem_req}, 2'b00);
    end else begin
      b  = 8'((rdata >> (8 * (3 - int'(k)))) & 32'hFF);
      h  = 16'((rdata >> (k[1] ? 0 : 16)) & 32'hFFFF);
      case (op)
        4'd1:    ld_val = {{24{b[7]}}, b};
        4'd2:    ld_val = {24'd0, b};
        4'd3:    ld_val = {{16{h[15]}}, h};
        4'd4:    ld_val = {16'd0, h};
        default: ld_val = rdata;
      endcase
      be = word ? 4'b1111 : half ? (k[1] ? 4'b0011 : 4'b1100) : (4'b1000 >> k);
      wd = (op == 4'd6) ? {4{d[7:0]}} : (op == 4'd7) ? {2{d[15:0]}} : d;
      err      = (ack_at == 0) || (ack_at > TO);
      exp_reqs = err ? TO : ack_at;
      e = '{dest: dest, wreg: wreg && ld && !err, data: ld_val, chk_data: ld && !err, err: err};
      sb_q.push_back(e);
      check({tag, " issue stall"}, stall_req, 1'b1);
      stalls = 1; reqs = 0; done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge clk);
        if (c == 0) begin
          mem_op = 4'd0; mem_addr = ~addr; mem_dest_data = ~d; mem_dest_addr = ~dest;
        end
        #1;
        if (dmem_req) begin
          reqs++;
          stalls += int'(stall_req);
          if (reqs == 1) begin
            check({tag, " bus addr"}, dmem_addr, {addr[31:2], 2'b00});
            check({tag, " bus we/be"}, {dmem_we, dmem_be}, {st, be});
            if (st) check({tag, " bus wdata"}, dmem_wdata, wd);
          end
          dmem_ack   = (reqs == ack_at);
          dmem_rdata = (reqs == ack_at) ? rdata : 32'hDEAD_BEEF;
        end else begin
          dmem_ack = 1'b0;
          done = 1;
          if (sb_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 1'b1, 1'b0);
          end else begin
            g = sb_q.pop_front();
            check({tag, " done addr/wreg/berr"}, {wb_dest_addr, wb_wreg, bus_err, stall_req},
                  {g.dest, g.wreg, g.err, 1'b0});
            if (g.chk_data) check({tag, " load data"}, wb_dest_data, g.data);
          end
          check({tag, " req cycles"}, reqs, exp_reqs);
          check({tag, " stall cycles"}, stalls, exp_reqs + 1);
        end
      end
      if (!done) check({tag, " completion timeout"}, 1'b0, 1'b1);
      @(negedge clk);
      #1;
      check({tag, " back idle"}, {stall_req, bus_err, dmem_req}, 3'b000);
    end
  endtask

  initial begin
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    mem_op = 4'd0; mem_addr = 32'h8; mem_dest_data = 32'h55; mem_dest_addr = 5'd3; mem_wreg = 1'b1;
    #12;
    check("reset outputs", {wb_dest_addr, wb_wreg, wb_dest_data, stall_req, addr_err, bus_err,
                            dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata}, 111'd0);
    @(negedge clk); rst = 1'b0;

    do_op("addu",  4'd0, 32'h0,   32'h1234,      5'd5,  1'b1, 32'h0,          0);
    do_op("op9",   4'd9, 32'h7,   32'hCAFE_0001, 5'd9,  1'b0, 32'h0,          0);
    do_op("lb",    4'd1, 32'h101, 32'h0,         5'd7,  1'b1, 32'h11A2_3344,  2);
    do_op("sh",    4'd7, 32'h202, 32'hBEEF,      5'd8,  1'b1, 32'h0,          1);
    do_op("lw_mis",4'd5, 32'h3,   32'h0,         5'd4,  1'b1, 32'h0,          1);
    do_op("lh_mis",4'd3, 32'h11,  32'h0,         5'd4,  1'b1, 32'h0,          1);
    do_op("lhu_to",4'd4, 32'h40,  32'h0,         5'd6,  1'b1, 32'h0,          0);
    do_op("lbu3",  4'd2, 32'h43,  32'h0,         5'd10, 1'b1, 32'h0102_0380,  1);
    do_op("lh2",   4'd3, 32'h46,  32'h0,         5'd11, 1'b1, 32'h1234_8001,  3);
    do_op("lw_lst",4'd5, 32'h48,  32'h0,         5'd12, 1'b1, 32'h8765_4321,  TO);
    do_op("sb1",   4'd6, 32'h51,  32'h1234_56A5, 5'd13, 1'b1, 32'h0,          1);
    do_op("sw",    4'd8, 32'h60,  32'h0BAD_F00D, 5'd14, 1'b1, 32'h0,          2);
    do_op("lb0",   4'd1, 32'h70,  32'h0,         5'd15, 1'b0, 32'h7F00_0000,  1);

    @(negedge clk);
    mem_op = 4'd5; mem_addr = 32'h80; mem_dest_addr = 5'd2; mem_wreg = 1'b1;
    @(negedge clk); mem_op = 4'd0;
    @(negedge clk); #1;
    check("pre-rst req", {dmem_req, stall_req}, 2'b11);
    #2 rst = 1'b1; #1;
    check("mid-rst drop", {dmem_req, stall_req}, 2'b00);
    @(negedge clk); rst = 1'b0;
    do_op("post_rst", 4'd5, 32'h84, 32'h0, 5'd3, 1'b1, 32'hA5A5_5A5A, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
